// File: rtl/encoder8to3_stream.sv
// encoder8to3_stream
//   Sequential 8-to-3 encoder. An accepted request vector is latched into a
//   mask. Then the binary index of every set bit is streamed out, one per
//   transfer, in priority order. This block is the inverse of the 3-to-8
//   decoder.
//
// Parameters
//   PRIORITY_HIGH  0: the lowest set bit goes first. 1: the highest set bit goes first.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request vector I is valid
//   in_ready   block can accept a vector (IDLE)
//   I[7:0]     request vector
//   out_valid  O holds a valid index (EMIT)
//   out_ready  consumer accepts O this cycle
//   O[2:0]     index of the highest-priority pending bit
//   out_last   O is the final index of the current vector
//   pop[3:0]   popcount of the latched vector, held until the next accept
//   none       one-cycle pulse after an all-zero vector is accepted
//   busy       a vector is latched and not yet fully emitted
module encoder8to3_stream #(
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] I,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] O,
  output logic       out_last,
  output logic [3:0] pop,
  output logic       none,
  output logic       busy
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] pop_q, pop_d;
  logic       none_q, none_d;
  logic [2:0] idx;
  logic       one_left;

  function automatic logic [3:0] popcnt(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 0; k < 8; k++) c = c + {3'b000, v[k]};
    return c;
  endfunction

  // Priority select over the mask. The bit written last in the loop wins.
  // The low-first order therefore scans downward, and the high-first order
  // scans upward. An empty mask gives index 0.
  always_comb begin
    idx = 3'd0;
    if (PRIORITY_HIGH) begin
      for (int k = 0; k < 8; k++)
        if (mask_q[k]) idx = 3'(k);
    end else begin
      for (int k = 7; k >= 0; k--)
        if (mask_q[k]) idx = 3'(k);
    end
  end

  // The mask has exactly one bit set.
  assign one_left = (mask_q != 8'd0) && ((mask_q & (mask_q - 8'd1)) == 8'd0);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pop_d   = pop_q;
    none_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (I != 8'd0) begin
            mask_d  = I;
            pop_d   = popcnt(I);
            state_d = EMIT;
          end else begin
            pop_d  = 4'd0;
            none_d = 1'b1;
          end
        end
      end
      EMIT: begin
        // in_valid is deliberately ignored here; nothing is queued.
        if (out_ready) begin
          mask_d = mask_q & ~(8'd1 << idx);
          if (one_left) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= 8'd0;
      pop_q   <= 4'd0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pop_q   <= pop_d;
      none_q  <= none_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign O         = idx;
  assign out_last  = (state_q == EMIT) && one_left;
  assign pop       = pop_q;
  assign none      = none_q;

endmodule
